// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side bundle for the data memory arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface data_mem_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic               p1_req;
    logic               p1_we;
    logic [ADDR_W-1:0]  p1_addr;
    logic [BURST_W-1:0] p1_len;
    logic [DATA_W-1:0]  p1_wdata;
    logic               p1_gnt;
    logic               p1_done;
    logic               p1_rvalid;
    logic [DATA_W-1:0]  p1_rdata;

    logic              MemWrite;
    logic              MemRead;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_len, p1_wdata,
        output p1_gnt, p1_done, p1_rvalid, p1_rdata,
        output MemWrite, MemRead, Mem_Addr, wr_data,
        input  rd_data
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_len, p1_wdata,
        input  p1_gnt, p1_done, p1_rvalid, p1_rdata,
        input  MemWrite, MemRead, Mem_Addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port word-addressed data memory.
// Port 0: single-beat priority path. Port 1: fixed-length bursts with starvation guard.
module data_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BURST_W  = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_arbiter_if.slave bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e             state_q;
    logic [BURST_W-1:0] cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               p0_rvalid_q;
    logic [DATA_W-1:0]  p0_rdata_q;
    logic               p1_rvalid_q;
    logic [DATA_W-1:0]  p1_rdata_q;

    logic idle;
    logic starved;
    logic p0_win;
    logic p1_win;
    logic burst;
    logic p1_beat;
    logic p1_we_eff;
    logic last;

    // Everything combinational is gated by reset so outputs drop immediately
    assign idle      = reset & (state_q == IDLE);
    assign burst     = reset & (state_q == BURST);
    assign starved   = (wait_q == WAIT_W'(MAX_WAIT));
    assign p0_win    = idle & bus.p0_req & ~(bus.p1_req & starved);
    assign p1_win    = idle & bus.p1_req & ~p0_win;
    assign p1_beat   = p1_win | burst;
    assign p1_we_eff = burst ? we_q : bus.p1_we;
    assign last      = p1_win ? (bus.p1_len == '0)
                              : (cnt_q == BURST_W'(1));

    assign bus.p0_gnt    = p0_win;
    assign bus.p1_gnt    = p1_beat;
    assign bus.p1_done   = p1_beat & last;
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p1_rdata  = p1_rdata_q;

    always_comb begin
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.Mem_Addr = '0;
        bus.wr_data  = '0;
        unique case (1'b1)
            p0_win: begin
                bus.MemWrite = bus.p0_we;
                bus.MemRead  = ~bus.p0_we;
                bus.Mem_Addr = bus.p0_addr;
                bus.wr_data  = bus.p0_wdata;
            end
            p1_win: begin
                bus.MemWrite = bus.p1_we;
                bus.MemRead  = ~bus.p1_we;
                bus.Mem_Addr = bus.p1_addr;
                bus.wr_data  = bus.p1_wdata;
            end
            burst: begin
                bus.MemWrite = we_q;
                bus.MemRead  = ~we_q;
                bus.Mem_Addr = addr_q;
                bus.wr_data  = bus.p1_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wait_q      <= '0;
            p0_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= p0_win & ~bus.p0_we;
            if (p0_win & ~bus.p0_we) p0_rdata_q <= bus.rd_data;
            p1_rvalid_q <= p1_beat & ~p1_we_eff;
            if (p1_beat & ~p1_we_eff) p1_rdata_q <= bus.rd_data;

            if (p1_win) begin
                wait_q <= '0;
            end else if (idle & bus.p1_req & ~starved) begin
                wait_q <= wait_q + WAIT_W'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (p1_win) begin
                        we_q   <= bus.p1_we;
                        addr_q <= bus.p1_addr + ADDR_W'(1);
                        cnt_q  <= bus.p1_len;
                        if (bus.p1_len != '0) state_q <= BURST;
                    end
                end
                BURST: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    cnt_q  <= cnt_q - BURST_W'(1);
                    if (cnt_q == BURST_W'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
